// File: rtl/fp_unpacker_if.sv
// fp_unpacker_if: operand/result bundle for the FP multiply/divide front end.
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. The producer holds its payload and valid until that edge.
// Ready may depend on state and enable, but never on valid.
// in_valid/in_ready carry operands in. out_valid/out_ready carry unpacked
// operands out.
interface fp_unpacker_if #(
    parameter int EXP_W = 10
);
    logic [31:0]      op_a;
    logic [31:0]      op_b;
    logic             sel;
    logic             in_valid;
    logic             in_ready;
    logic [23:0]      mantissa_a;
    logic [23:0]      mantissa_b;
    logic [EXP_W-1:0] exponent_a;
    logic [EXP_W-1:0] exponent_b;
    logic             sign_out;
    logic [3:0]       flags;
    logic             sel_out;
    logic             out_valid;
    logic             out_ready;

    // Upstream/downstream side: supplies operands and consumes results.
    modport master (
        output op_a, op_b, sel, in_valid, out_ready,
        input  in_ready, mantissa_a, mantissa_b, exponent_a, exponent_b,
               sign_out, flags, sel_out, out_valid
    );

    // Unpacker side.
    modport slave (
        input  op_a, op_b, sel, in_valid, out_ready,
        output in_ready, mantissa_a, mantissa_b, exponent_a, exponent_b,
               sign_out, flags, sel_out, out_valid
    );
endinterface

// File: rtl/fp_unpacker.sv
// fp_unpacker: splits two IEEE 754 singles into sign/exponent/24-bit mantissa.
// Subnormals are pre-normalized by an iterative left shift, so bit 23 of each
// finite nonzero mantissa is set when out_valid rises.
// It also classifies the special result cases as {nan, inf, zero, dbz}.
// Optional feature macro UNPACK_DAZ_EN selects denormals-are-zero. Subnormal
// inputs are then treated as zero, no shifter is built, and NORM lasts one cycle.
module fp_unpacker #(
    parameter int EXP_W      = 10,
    parameter int SHIFT_STEP = 1    // 1, 2 or 4 bits of shift per NORM cycle
) (
    input  logic         clk,
    input  logic         arst,
    input  logic         en,
    fp_unpacker_if.slave bus,
    output logic [1:0]   o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_NORM = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t           r_state;
    logic [23:0]      r_man_a, r_man_b;
    logic [EXP_W-1:0] r_exp_a, r_exp_b;
    logic             r_sign, r_sel, r_out_valid;
    logic [3:0]       r_flags;
    // Operand class bits: nan, inf, zero. Finite nonzero means none of them is set.
    logic             r_a_nan, r_a_inf, r_a_zero;
    logic             r_b_nan, r_b_inf, r_b_zero;

    logic [2:0]       w_cls_a, w_cls_b;
    logic             w_a_fin, w_b_fin;
    logic             w_nan, w_inf_raw, w_zero_raw, w_dbz;
    logic [3:0]       w_flags;

    // Class of a raw operand as {nan, inf, zero}.
    function automatic logic [2:0] op_class(input logic [31:0] op);
        logic [7:0]  ef;
        logic [22:0] fr;
        ef = op[30:23];
        fr = op[22:0];
`ifdef UNPACK_DAZ_EN
        return {(ef == 8'hFF) && (fr != 23'd0),
                (ef == 8'hFF) && (fr == 23'd0),
                (ef == 8'h00)};
`else
        return {(ef == 8'hFF) && (fr != 23'd0),
                (ef == 8'hFF) && (fr == 23'd0),
                (ef == 8'h00) && (fr == 23'd0)};
`endif
    endfunction

    // Mantissa as captured on accept. The hidden bit is cleared for exp field 0.
    function automatic logic [23:0] cap_man(input logic [31:0] op);
        if (op[30:23] != 8'h00) return {1'b1, op[22:0]};
`ifdef UNPACK_DAZ_EN
        return 24'd0;
`else
        return {1'b0, op[22:0]};
`endif
    endfunction

    // Exponent as captured on accept. A subnormal starts at exponent 1.
    function automatic logic [EXP_W-1:0] cap_exp(input logic [31:0] op);
        if (op[30:23] != 8'h00) return EXP_W'(op[30:23]);
`ifdef UNPACK_DAZ_EN
        return '0;
`else
        return (op[22:0] != 23'd0) ? EXP_W'(1) : '0;
`endif
    endfunction

`ifndef UNPACK_DAZ_EN
    logic [2:0] w_sh_a, w_sh_b;
    logic       w_need_shift;

    // Shift for this cycle: leading zeros, capped at SHIFT_STEP. A zero mantissa gives 0.
    function automatic logic [2:0] shift_amt(input logic [23:0] m);
        logic [2:0] s;
        s = 3'd0;
        if (m != 24'd0) begin
            for (int i = 0; i < SHIFT_STEP; i++) begin
                if ((s == 3'(i)) && !m[5'(23 - i)]) s = s + 3'd1;
            end
        end
        return s;
    endfunction

    // Per-operand shift amounts. Both operands move in the same NORM cycle.
    always_comb begin
        w_sh_a       = shift_amt(r_man_a);
        w_sh_b       = shift_amt(r_man_b);
        w_need_shift = (w_sh_a != 3'd0) || (w_sh_b != 3'd0);
    end
`endif

    // Classify the raw operands presented on the bus.
    always_comb begin
        w_cls_a = op_class(bus.op_a);
        w_cls_b = op_class(bus.op_b);
    end

    // Result special-case flags, prioritized nan > inf > zero. dbz stands alone.
    always_comb begin
        w_a_fin    = !r_a_nan && !r_a_inf;
        w_b_fin    = !r_b_nan && !r_b_inf;
        w_nan      = r_a_nan || r_b_nan ||
                     (!r_sel && ((r_a_zero && r_b_inf) || (r_a_inf && r_b_zero))) ||
                     ( r_sel && ((r_a_zero && r_b_zero) || (r_a_inf && r_b_inf)));
        w_dbz      = r_sel && w_a_fin && !r_a_zero && r_b_zero;
        w_inf_raw  = r_sel ? ((r_a_inf && w_b_fin) || w_dbz)
                           : ((r_a_inf && !r_b_zero) || (r_b_inf && !r_a_zero));
        w_zero_raw = r_sel ? ((r_a_zero && !r_b_zero) || (w_a_fin && r_b_inf))
                           : ((r_a_zero && w_b_fin) || (r_b_zero && w_a_fin));
        w_flags    = {w_nan,
                      !w_nan && w_inf_raw,
                      !w_nan && !w_inf_raw && w_zero_raw,
                      w_dbz};
    end

    // Control FSM and datapath registers. Everything freezes while en is low.
    always_ff @(posedge clk) begin
        if (arst) begin
            r_state     <= S_IDLE;
            r_man_a     <= '0;
            r_man_b     <= '0;
            r_exp_a     <= '0;
            r_exp_b     <= '0;
            r_sign      <= 1'b0;
            r_sel       <= 1'b0;
            r_out_valid <= 1'b0;
            r_flags     <= '0;
            r_a_nan     <= 1'b0;
            r_a_inf     <= 1'b0;
            r_a_zero    <= 1'b0;
            r_b_nan     <= 1'b0;
            r_b_inf     <= 1'b0;
            r_b_zero    <= 1'b0;
        end else if (en) begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_man_a  <= cap_man(bus.op_a);
                        r_man_b  <= cap_man(bus.op_b);
                        r_exp_a  <= cap_exp(bus.op_a);
                        r_exp_b  <= cap_exp(bus.op_b);
                        r_sign   <= bus.op_a[31] ^ bus.op_b[31];
                        r_sel    <= bus.sel;
                        {r_a_nan, r_a_inf, r_a_zero} <= w_cls_a;
                        {r_b_nan, r_b_inf, r_b_zero} <= w_cls_b;
                        r_state  <= S_NORM;
                    end
                end
                S_NORM: begin
`ifndef UNPACK_DAZ_EN
                    if (w_need_shift) begin
                        r_man_a <= r_man_a << w_sh_a;
                        r_man_b <= r_man_b << w_sh_b;
                        r_exp_a <= r_exp_a - EXP_W'(w_sh_a);
                        r_exp_b <= r_exp_b - EXP_W'(w_sh_b);
                    end else
`endif
                    begin
                        r_flags     <= w_flags;
                        r_out_valid <= 1'b1;
                        r_state     <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready   = (r_state == S_IDLE) && en;
    assign bus.mantissa_a = r_man_a;
    assign bus.mantissa_b = r_man_b;
    assign bus.exponent_a = r_exp_a;
    assign bus.exponent_b = r_exp_b;
    assign bus.sign_out   = r_sign;
    assign bus.flags      = r_flags;
    assign bus.sel_out    = r_sel;
    assign bus.out_valid  = r_out_valid;
    assign o_dbg_state    = r_state;

endmodule

// File: doc/fp_unpacker.md
Name: fp_unpacker

Overview:
- Front end of the FP multiply/divide datapath: receives two IEEE 754 single-precision operands and splits each into sign, exponent and a 24-bit mantissa with the hidden bit restored.
- Pre-normalizes subnormal operands with an iterative left-shift FSM, so the multiplier and divider always receive mantissas with bit 23 set.
- Classifies special cases for the result (NaN, Inf, zero, divide-by-zero).
- Sits ahead of the multiplier/divider; it is the input-side counterpart of the output normalizer.

Parameters:
EXP_W, 10, width of the two's-complement exponent outputs (matches downstream exponent logic)
SHIFT_STEP, 1, maximum mantissa left-shift per NORM cycle (legal values 1, 2, 4)

Ports:
clk  input  1  clock
arst  input  1  reset, synchronous, active-high
en  input  1  global enable; when low, all state and outputs hold
op_a  input  32  operand A, IEEE 754 single
op_b  input  32  operand B, IEEE 754 single
sel  input  1  0 = multiply, 1 = divide (A/B)
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands
mantissa_a  output  24  normalized mantissa A
mantissa_b  output  24  normalized mantissa B
exponent_a  output  EXP_W  unbiased-field exponent A, two's complement
exponent_b  output  EXP_W  exponent B, two's complement
sign_out  output  1  result sign = sign_a XOR sign_b
flags  output  4  {nan, inf, zero, dbz}
sel_out  output  1  registered copy of sel
out_valid  output  1  outputs valid
out_ready  input  1  downstream accepts outputs

Behaviour:
- Reset: clk and arst only; reset is synchronous, active-high. Takes effect at the next clk edge regardless of en.
  - State goes to IDLE; all outputs are 0 except in_ready, which is 1 once in IDLE.
  - Any in-flight operation is discarded.
- States and transitions: IDLE, NORM, OUT.
- in_ready = (state==IDLE) && en. Accept occurs when in_valid && in_ready at a clk edge.
- On accept, capture operands and move to NORM:
  - Normal operand (exp field 1..254): mantissa = {1, frac}, exponent = exp field, zero-extended.
  - Subnormal (exp 0, frac≠0): mantissa = {0, frac}, exponent = 1.
  - Zero: mantissa = 0, exponent = 0.
  - Inf/NaN (exp 255): mantissa = {1, frac}, exponent = 255; no shifting.
  - Record the class bits for both operands. Register sign_out and sel_out.
- NORM, each enabled cycle, per operand whose mantissa is nonzero with bit23 = 0:
  - Shift left by s = min(SHIFT_STEP, leading zeros).
  - Subtract s from the exponent (two's complement; it may go negative, minimum 1-23 = -22).
  - Both operands shift in the same cycle.
  - When neither operand needs shifting, compute flags and go to OUT on the next edge.
- Latency: out_valid is asserted 2 + ceil(k/SHIFT_STEP) enabled cycles after accept, where k is the larger leading-zero count of the two operands. Normal operands take 2 cycles.
- OUT: out_valid = 1 and all outputs are held stable. If out_ready, go to IDLE (out_valid = 0 the next cycle). A new accept is possible one cycle after the transfer.
- en low: FSM, counters and outputs freeze; in_ready = 0; out_valid keeps its value, but no transfer completes.
- Flags, priority nan > inf > zero; dbz is independent:
  - nan: either operand NaN; mul 0×Inf; div 0/0; div Inf/Inf.
  - inf: mul Inf×(nonzero); div Inf/(finite); div (nonzero finite)/0.
  - dbz: div (nonzero finite)/0, set together with inf.
  - zero: mul 0×(finite); div 0/(nonzero); div (finite)/Inf.
- Mantissa and exponent values for special-case operands are undefined; downstream logic uses flags.

Optional Feature:
UNPACK_DAZ_EN (denormals-are-zero):
- Defined: subnormal inputs are classified and emitted as zero (mantissa 0, exponent 0). NORM always lasts one cycle, so latency is always 2. No shifter is built.
- Undefined: subnormals are pre-normalized as above.

Test Plan:
- mul 0x3F800000 × 0x40000000 -> out_valid 2 cycles after accept; mantissa_a = mantissa_b = 0x800000; exponent_a = 127; exponent_b = 128; sign_out = 0; flags = 0.
- mul 0x00000001 × 0x3F800000 (SHIFT_STEP=1) -> out_valid after 25 cycles; mantissa_a = 0x800000; exponent_a = 10'h3EA (-22). With UNPACK_DAZ_EN: latency 2, flags.zero = 1.
- div 0xBF800000 / 0x00000000 -> flags = {0,1,0,1}, sign_out = 1. Then div 0/0 -> flags.nan = 1, dbz = 0.
- Backpressure: hold out_ready = 0 for 5 cycles in OUT -> outputs stable, in_ready = 0. Raise out_ready -> out_valid = 0 and in_ready = 1 the next cycle.
- Assert arst during NORM of subnormal operand 0x00000001 -> next cycle state IDLE, out_valid = 0, all outputs 0, in_ready = 1.
- Drop en for 3 cycles in NORM with op_a 0x00000010 -> latency extends by exactly 3 cycles; mantissa_a = 0x800000, exponent_a = -18.
